// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous update, guard blanking,
// PWM brightness and leading-zero blanking. Optional lamp test via SEVEN_SEG_LAMP_TEST_EN.
module seven_seg_scanner #(
  parameter int CC           = 1,
  parameter int FREQ         = 2_000,
  parameter int SCAN_PER_SEC = 25,
  parameter int GUARD        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_load,
  input  logic [3:0]  brightness,
  input  logic        lzb_en,
  input  logic [3:0]  dp_mask,
`ifdef SEVEN_SEG_LAMP_TEST_EN
  input  logic        lamp_test,
`endif
  output logic [7:0]  seven_seg,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int D  = FREQ / (4 * SCAN_PER_SEC);
  localparam int SW = (D > 1) ? $clog2(D) : 1;
  localparam logic [7:0] SEG_OFF = (CC != 0) ? 8'h00 : 8'hFF;
  localparam logic [3:0] EN_OFF  = (CC != 0) ? 4'hF : 4'h0;

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    dig_idx_q, dig_idx_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_v_q, pend_v_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    seven_seg_q, seven_seg_d;
  logic [3:0]    digit_en_q, digit_en_d;

  logic          slot_wrap;
  logic          boundary;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_abcdefg;
  logic [7:0]    seg_word;
  logic [3:0]    digit_sel;
  logic          in_guard;
  logic          pwm_lit;
  logic          blank;
  logic          drive_on;
  logic          lamp;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

`ifdef SEVEN_SEG_LAMP_TEST_EN
  assign lamp = lamp_test;
`else
  assign lamp = 1'b0;
`endif

  // Scan counters and the tear-free update path.
  always_comb begin
    slot_wrap    = (slot_cnt_q == SW'(D - 1));
    boundary     = slot_wrap && (dig_idx_q == 2'd3);
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    dig_idx_d    = slot_wrap ? dig_idx_q + 2'd1 : dig_idx_q;
    // pwm_cnt is aligned so it reads 0 on the first PWM cycle of every slot
    pwm_cnt_d    = (slot_cnt_d == SW'(GUARD)) ? 4'd0 : pwm_cnt_q + 4'd1;
    pending_d    = pending_q;
    pend_v_d     = pend_v_q;
    active_d     = active_q;
    frame_done_d = boundary;
    if (bcd_load) begin
      pending_d = bcd_in;
      pend_v_d  = 1'b1;
    end
    if (boundary) begin
      pend_v_d = 1'b0;
      if (bcd_load) begin
        active_d = bcd_in;
      end else if (pend_v_q) begin
        active_d = pending_q;
      end
    end
  end

  // Output decode from the current counters; registered below.
  always_comb begin
    cur_digit   = active_q[{dig_idx_q, 2'b00} +: 4];
    seg_abcdefg = seg_decode(cur_digit);
    seg_word    = {dp_mask[dig_idx_q], seg_abcdefg};
    digit_sel   = 4'b0001 << dig_idx_q;
    in_guard    = (slot_cnt_q < SW'(GUARD));
    pwm_lit     = (brightness == 4'hF) || (pwm_cnt_q < brightness);
    blank       = lzb_en && (((dig_idx_q == 2'd3) && (active_q[15:12] == 4'd0)) ||
                             ((dig_idx_q == 2'd2) && (active_q[15:8] == 8'd0)));
    drive_on    = !in_guard && (lamp || (pwm_lit && !blank));
    if (lamp) begin
      seg_word = 8'hFF;
    end
    seven_seg_d = drive_on ? seg_word : 8'h00;
    digit_en_d  = drive_on ? ~digit_sel : 4'hF;
    if (CC == 0) begin
      seven_seg_d = ~seven_seg_d;
      digit_en_d  = ~digit_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= 2'd0;
      pwm_cnt_q    <= 4'd0;
      active_q     <= 16'h0000;
      pending_q    <= 16'h0000;
      pend_v_q     <= 1'b0;
      frame_done_q <= 1'b0;
      seven_seg_q  <= SEG_OFF;
      digit_en_q   <= EN_OFF;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      frame_done_q <= frame_done_d;
      seven_seg_q  <= seven_seg_d;
      digit_en_q   <= digit_en_d;
    end
  end

  assign seven_seg  = seven_seg_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: common-cathode and common-anode instances share stimulus.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_load;
  logic [3:0]  brightness;
  logic        lzb_en;
  logic [3:0]  dp_mask;
  logic [7:0]  seven_seg, seven_seg_ca;
  logic [3:0]  digit_en, digit_en_ca;
  logic        frame_done, frame_done_ca;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  seven_seg_scanner #(.CC(1)) u_dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_load(bcd_load),
    .brightness(brightness), .lzb_en(lzb_en), .dp_mask(dp_mask),
`ifdef SEVEN_SEG_LAMP_TEST_EN
    .lamp_test(1'b0),
`endif
    .seven_seg(seven_seg), .digit_en(digit_en), .frame_done(frame_done)
  );

  seven_seg_scanner #(.CC(0)) u_dut_ca (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_load(bcd_load),
    .brightness(brightness), .lzb_en(lzb_en), .dp_mask(dp_mask),
`ifdef SEVEN_SEG_LAMP_TEST_EN
    .lamp_test(1'b0),
`endif
    .seven_seg(seven_seg_ca), .digit_en(digit_en_ca), .frame_done(frame_done_ca)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Returns at the negedge where frame_done is high (outputs show position 79).
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL frame_timeout: observed no frame_done expected pulse within 200 cycles");
    end
  endtask

  // Outputs at frame position t (digit t/20, slot t%20) of the next frame.
  task automatic at_pos(input int t);
    wait_frame();
    repeat (t + 1) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    bcd_in   = v;
    bcd_load = 1'b1;
    @(negedge clk);
    bcd_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bcd_in = 16'h0; bcd_load = 1'b0;
    brightness = 4'hF; lzb_en = 1'b0; dp_mask = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", seven_seg, 8'h00);
    chk("rst_en", {4'h0, digit_en}, 8'h0F);
    chk("rst_fd", {7'h0, frame_done}, 8'h00);
    chk("rst_seg_ca", seven_seg_ca, 8'hFF);
    chk("rst_en_ca", {4'h0, digit_en_ca}, 8'h00);
    rst = 1'b0;

    // Basic display of 1234 at full brightness
    load(16'h1234);
    at_pos(0);  chk("guard_seg", seven_seg, 8'h00);
    chk("guard_en", {4'h0, digit_en}, 8'h0F);
    at_pos(1);  chk("guard1_en", {4'h0, digit_en}, 8'h0F);
    at_pos(2);  chk("d0_seg", seven_seg, 8'h33);
    chk("d0_en", {4'h0, digit_en}, 8'h0E);
    at_pos(25); chk("d1_seg", seven_seg, 8'h79);
    chk("d1_en", {4'h0, digit_en}, 8'h0D);
    at_pos(45); chk("d2_seg", seven_seg, 8'h6D);
    chk("d2_en", {4'h0, digit_en}, 8'h0B);
    at_pos(65); chk("d3_seg", seven_seg, 8'h30);
    chk("d3_en", {4'h0, digit_en}, 8'h07);

    wait_frame();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) break;
    end
    chk("frame_period", 8'(n), 8'd80);

    // PWM at brightness 4: lit on the first four PWM cycles of the slot
    brightness = 4'd4;
    at_pos(0);
    for (int t = 0; t < 18; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("pwm4_pos%0d", t), {4'h0, digit_en},
          (t >= 2 && t < 6) ? 8'h0E : 8'h0F);
    end

    brightness = 4'd0;
    at_pos(0);
    for (int t = 0; t < 80; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("dark_pos%0d", t), {digit_en, seven_seg[3:0]}, 8'hF0);
    end
    brightness = 4'hF;

    // Two loads in one frame: only the last one is shown, at the boundary
    wait_frame();
    load(16'h0000);
    load(16'h0509);
    wait_frame();
    chk("tear_old_d3", seven_seg, 8'h30);
    repeat (3) @(posedge clk);
    #1;
    chk("tear_new_d0", seven_seg, 8'h7B);
    at_pos(22); chk("tear_d1", seven_seg, 8'h7E);
    at_pos(42); chk("tear_d2", seven_seg, 8'h5B);
    at_pos(62); chk("tear_d3", seven_seg, 8'h7E);

    // Leading-zero blanking with all dps requested
    lzb_en = 1'b1; dp_mask = 4'hF;
    load(16'h0007);
    at_pos(2);  chk("lzb_d0", seven_seg, 8'hF0);
    at_pos(22); chk("lzb_d1", seven_seg, 8'hFE);
    at_pos(42); chk("lzb_d2_seg", seven_seg, 8'h00);
    chk("lzb_d2_en", {4'h0, digit_en}, 8'h0F);
    at_pos(62); chk("lzb_d3_seg", seven_seg, 8'h00);
    chk("lzb_d3_en", {4'h0, digit_en}, 8'h0F);
    dp_mask = 4'h0;
    load(16'h00A0);
    at_pos(22); chk("nonbcd_d1", seven_seg, 8'h00);
    at_pos(2);  chk("lzb_d0_zero", seven_seg, 8'h7E);

    // Load coincident with the boundary goes straight to active
    lzb_en = 1'b0;
    wait_frame();
    repeat (79) @(negedge clk);
    bcd_in = 16'h4321; bcd_load = 1'b1;
    @(negedge clk);
    bcd_load = 1'b0;
    chk("bnd_fd", {7'h0, frame_done}, 8'h01);
    chk("bnd_old_d3", seven_seg, 8'h7E);
    repeat (3) @(posedge clk);
    #1;
    chk("bnd_new_d0", seven_seg, 8'h30);
    at_pos(62); chk("bnd_d3_next", seven_seg, 8'h33);

    // Reset mid-slot-2 drops the pending load and restarts scanning
    at_pos(40);
    load(16'h9999);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_seg", seven_seg, 8'h00);
    chk("mrst_en", {4'h0, digit_en}, 8'h0F);
    chk("mrst_fd", {7'h0, frame_done}, 8'h00);
    chk("mrst_seg_ca", seven_seg_ca, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) break;
    end
    chk("mrst_first_frame", 8'(n), 8'd80);
    chk("mrst_d3", seven_seg, 8'h7E);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_d0_lost", seven_seg, 8'h7E);

    // Common-anode polarity with a decimal point on digit 2
    dp_mask = 4'b0100;
    load(16'h1200);
    at_pos(42);
    chk("cc1_d2_seg", seven_seg, 8'hED);
    chk("cc1_d2_en", {4'h0, digit_en}, 8'h0B);
    chk("cc0_d2_seg", seven_seg_ca, 8'h12);
    chk("cc0_d2_en", {4'h0, digit_en_ca}, 8'h04);
    at_pos(2);
    chk("cc0_d0_seg", seven_seg_ca, 8'h81);
    chk("cc0_d0_en", {4'h0, digit_en_ca}, 8'h01);
    at_pos(0);
    chk("cc0_guard_seg", seven_seg_ca, 8'hFF);
    chk("cc0_guard_en", {4'h0, digit_en_ca}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
